// File: rtl/npu_mem_responder.sv
// Word-organised SRAM responder for the NPU core memory port: one request per cycle, fixed-latency in-order acks.
// Optional request counters (rd_count/wr_count) are built when NPU_MEM_STATS_EN is defined.
module npu_mem_responder #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH_WORDS  = 1024,
    parameter int                    READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] BAD_DATA     = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_we,
    input  logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_valid,
    output logic                  mem_err
`ifdef NPU_MEM_STATS_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    // Handshake: any cycle with mem_we|mem_re is accepted (no ready); each accepted request
    // produces exactly one mem_valid pulse READ_LATENCY cycles later, strictly in order.
    localparam int OFF   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  req_any;
    logic                  req_rd;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  addr_bad;
    logic                  req_err;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] req_data;

    assign req_any      = mem_we | mem_re;
    assign req_rd       = mem_re & ~mem_we;
    assign misaligned   = |(mem_addr & OFF_MASK);
    assign out_of_range = |(mem_addr >> (IDX_W + OFF));
    assign addr_bad     = misaligned | out_of_range;
    assign req_err      = req_any & (addr_bad | (mem_we & mem_re));
    assign word_idx     = mem_addr[IDX_W+OFF-1:OFF];
    assign req_data     = addr_bad ? BAD_DATA : mem[word_idx];

    // A we&re collision is flagged but still performs the write; only a bad address blocks it.
    always_ff @(posedge clk) begin
        if (mem_we && !addr_bad) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    logic                  tail_vld;
    logic                  tail_rd;
    logic [DATA_WIDTH-1:0] tail_data;

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign tail_vld  = req_any;
            assign tail_rd   = req_rd;
            assign tail_data = req_data;
        end else begin : g_pipe
            localparam int S = READ_LATENCY - 1;
            logic [S-1:0]          vld_q;
            logic [S-1:0]          rd_q;
            logic [DATA_WIDTH-1:0] data_q [S];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    rd_q  <= '0;
                    for (int i = 0; i < S; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= req_any;
                    rd_q[0]   <= req_rd;
                    data_q[0] <= req_data;
                    for (int i = 1; i < S; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        rd_q[i]   <= rd_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign tail_vld  = vld_q[S-1];
            assign tail_rd   = rd_q[S-1];
            assign tail_data = data_q[S-1];
        end
    endgenerate

    // Output register is the final pipeline stage; rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            mem_valid <= tail_vld;
            if (tail_vld) begin
                mem_rdata <= tail_rd ? tail_data : '0;
            end
            mem_err <= mem_err | req_err;
        end
    end

`ifdef NPU_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (req_rd) begin
                rd_count <= rd_count + 32'd1;
            end
            if (mem_we) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
